// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: eight synchronized sources, pending/enable/edge
// state, and four CPU request lines each serving a fixed-priority source pair.
module irq_controller #(
  parameter logic [15:0] BASE        = 16'h1010,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  src,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  rdata,
  output logic        interrupt_0,
  output logic        interrupt_1,
  output logic        interrupt_2,
  output logic        interrupt_3,
  input  logic        interrupt_0_clr,
  input  logic        interrupt_1_clr,
  input  logic        interrupt_2_clr,
  input  logic        interrupt_3_clr
);

  localparam int unsigned NumSrc   = 8;
  localparam int unsigned NumLines = 4;
  localparam int unsigned OffW     = 3;

  localparam logic [OffW-1:0] OffEnable  = 3'd0;
  localparam logic [OffW-1:0] OffPending = 3'd1;
  localparam logic [OffW-1:0] OffEdge    = 3'd2;
  localparam logic [OffW-1:0] OffSwTrig  = 3'd3;
  localparam logic [OffW-1:0] OffActive  = 3'd4;

  logic [NumSrc-1:0]   syncChain [SYNC_STAGES];
  logic [NumSrc-1:0]   srcSync;
  logic [NumSrc-1:0]   srcPrev;
  logic [NumSrc-1:0]   enableReg;
  logic [NumSrc-1:0]   pendingReg;
  logic [NumSrc-1:0]   edgeReg;
  logic [NumLines-1:0] irqReg;
  logic [NumLines-1:0] ackReq;

  logic                sel;
  logic [OffW-1:0]     offset;
  logic                wrEnable;
  logic                wrPending;
  logic                wrEdge;
  logic                wrSwTrig;

  logic [NumSrc-1:0]   activeVec;
  logic [NumSrc-1:0]   setVec;
  logic [NumSrc-1:0]   ackClr;
  logic [NumSrc-1:0]   clrVec;
  logic [NumLines-1:0] irqNext;
  logic [7:0]          readMux;

  assign sel       = (addr[15:3] == BASE[15:3]);
  assign offset    = addr[2:0];
  assign wrEnable  = we & sel & (offset == OffEnable);
  assign wrPending = we & sel & (offset == OffPending);
  assign wrEdge    = we & sel & (offset == OffEdge);
  assign wrSwTrig  = we & sel & (offset == OffSwTrig);

  assign ackReq    = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr};
  assign srcSync   = syncChain[SYNC_STAGES-1];
  assign activeVec = pendingReg & enableReg;

  // Source synchronizer plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        syncChain[i] <= '0;
      end
      srcPrev <= '0;
    end else begin
      syncChain[0] <= src;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        syncChain[i] <= syncChain[i-1];
      end
      srcPrev <= srcSync;
    end
  end

  // Set/clear masks; an ack retires only the lower-numbered active source of its pair
  always_comb begin
    setVec  = '0;
    ackClr  = '0;
    irqNext = '0;
    for (int i = 0; i < int'(NumSrc); i++) begin
      if (edgeReg[i]) begin
        setVec[i] = srcSync[i] & ~srcPrev[i];
      end else begin
        setVec[i] = srcSync[i];
      end
    end
    if (wrSwTrig) begin
      setVec = setVec | wdata;
    end
    for (int k = 0; k < int'(NumLines); k++) begin
      irqNext[k] = activeVec[2*k] | activeVec[2*k+1];
      if (ackReq[k]) begin
        if (activeVec[2*k]) begin
          ackClr[2*k] = 1'b1;
        end else if (activeVec[2*k+1]) begin
          ackClr[2*k+1] = 1'b1;
        end
      end
    end
    clrVec = ackClr | (wrPending ? wdata : 8'h00);
  end

  always_comb begin
    readMux = '0;
    case (offset)
      OffEnable:  readMux = enableReg;
      OffPending: readMux = pendingReg;
      OffEdge:    readMux = edgeReg;
      OffActive:  readMux = activeVec;
      default:    readMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enableReg  <= '0;
      pendingReg <= '0;
      edgeReg    <= '0;
      irqReg     <= '0;
      rdata      <= '0;
    end else begin
      pendingReg <= setVec | (pendingReg & ~clrVec);
      irqReg     <= irqNext;
      if (wrEnable) begin
        enableReg <= wdata;
      end
      if (wrEdge) begin
        edgeReg <= wdata;
      end
      // Read mux sees pre-write register values
      if (re && sel) begin
        rdata <= readMux;
      end
    end
  end

  assign interrupt_0 = irqReg[0];
  assign interrupt_1 = irqReg[1];
  assign interrupt_2 = irqReg[2];
  assign interrupt_3 = irqReg[3];

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_irq_controller;

  localparam logic [15:0] BASE = 16'h1010;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic [3:0]  clrLines;
  logic [7:0]  rdata;
  logic        irq0, irq1, irq2, irq3;
  logic [3:0]  irqVec;

  int checks = 0;
  int errors = 0;

  // Behavioural reference state
  logic [7:0] mEnable, mPending, mEdge, mRdata;
  logic [3:0] mIrq;
  logic [7:0] hist [SYNC+1];
  bit         modelValid = 0;

  assign irqVec = {irq3, irq2, irq1, irq0};

  irq_controller #(.BASE(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .src(src), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata),
    .interrupt_0(irq0), .interrupt_1(irq1), .interrupt_2(irq2), .interrupt_3(irq3),
    .interrupt_0_clr(clrLines[0]), .interrupt_1_clr(clrLines[1]),
    .interrupt_2_clr(clrLines[2]), .interrupt_3_clr(clrLines[3])
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, applied to the inputs seen at this edge
  task automatic modelStep();
    logic [7:0] s, sd, setM, clrM, act;
    bit inWin;
    int off;
    if (!reset) begin
      mEnable = 0; mPending = 0; mEdge = 0; mRdata = 0; mIrq = 0;
      for (int j = 0; j <= SYNC; j++) hist[j] = 0;
      modelValid = 1;
      return;
    end
    inWin = ((addr >> 3) == (BASE >> 3));
    off   = int'(addr % 16'd8);
    s     = hist[SYNC-1];
    sd    = hist[SYNC];
    act   = mPending & mEnable;
    setM  = 0;
    clrM  = 0;
    for (int i = 0; i < 8; i++) begin
      if (mEdge[i] ? (s[i] && !sd[i]) : s[i]) setM[i] = 1'b1;
    end
    if (we && inWin && off == 3) setM = setM | wdata;
    if (we && inWin && off == 1) clrM = clrM | wdata;
    for (int k = 0; k < 4; k++) begin
      if (clrLines[k]) begin
        if (act[2*k]) clrM[2*k] = 1'b1;
        else if (act[2*k+1]) clrM[2*k+1] = 1'b1;
      end
      mIrq[k] = act[2*k] | act[2*k+1];
    end
    if (re && inWin) begin
      case (off)
        0: mRdata = mEnable;
        1: mRdata = mPending;
        2: mRdata = mEdge;
        4: mRdata = act;
        default: mRdata = 0;
      endcase
    end
    mPending = setM | (mPending & ~clrM);
    if (we && inWin && off == 0) mEnable = wdata;
    if (we && inWin && off == 2) mEdge = wdata;
    for (int j = SYNC; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = src;
  endtask

  // Compare process: every cycle after the first reset edge
  always @(posedge clk) begin
    modelStep();
    #1;
    if (modelValid) begin
      check8("model_rdata", rdata, mRdata);
      check8("model_irq", {4'h0, irqVec}, {4'h0, mIrq});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    addr = BASE + 16'(off); wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input int off, output logic [7:0] d);
    addr = BASE + 16'(off); re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic expectReg(input string name, input int off, input logic [7:0] exp);
    logic [7:0] d;
    rd(off, d);
    check8(name, d, exp);
  endtask

  initial begin
    reset = 1'b0; src = 8'hFF; addr = BASE; wdata = 8'hFF; we = 1'b1; re = 1'b1;
    clrLines = 4'h0;
    // Reset values
    tick(); check8("reset_irq_c1", {4'h0, irqVec}, 8'h00);
    tick(); check8("reset_irq_c2", {4'h0, irqVec}, 8'h00);
    check8("reset_rdata", rdata, 8'h00);
    reset = 1'b1; src = 8'h00; we = 1'b0; re = 1'b0;
    tick(); check8("post_reset_irq", {4'h0, irqVec}, 8'h00);
    for (int r = 0; r < 8; r++) expectReg("reset_reg", r, 8'h00);

    // Edge path on source 0
    wr(2, 8'h01); wr(0, 8'h01);
    src = 8'h01; tick(); src = 8'h00;
    tick(); tick();
    check8("edge_irq0_early", {7'h0, irq0}, 8'h00);
    tick();
    check8("edge_irq0_t3", {7'h0, irq0}, 8'h01);
    expectReg("edge_pending", 1, 8'h01);
    clrLines = 4'h1; tick(); clrLines = 4'h0;
    tick(); check8("edge_irq0_cleared", {7'h0, irq0}, 8'h00);
    expectReg("edge_pending_clr", 1, 8'h00);

    // Priority within pair 1
    wr(2, 8'h0C); wr(0, 8'h0C); wr(3, 8'h0C);
    tick(); check8("prio_irq1_rise", {7'h0, irq1}, 8'h01);
    clrLines = 4'h2; tick(); clrLines = 4'h0;
    tick(); check8("prio_irq1_held", {7'h0, irq1}, 8'h01);
    expectReg("prio_pending_1", 1, 8'h08);
    clrLines = 4'h2; tick(); clrLines = 4'h0;
    tick(); check8("prio_irq1_low", {7'h0, irq1}, 8'h00);
    expectReg("prio_pending_2", 1, 8'h00);

    // Level source 4
    wr(2, 8'h00); wr(0, 8'h10);
    src = 8'h10;
    repeat (4) tick();
    check8("level_irq2", {7'h0, irq2}, 8'h01);
    clrLines = 4'h4; tick(); clrLines = 4'h0;
    repeat (3) begin
      tick(); check8("level_irq2_held", {7'h0, irq2}, 8'h01);
    end
    src = 8'h00;
    repeat (3) tick();
    clrLines = 4'h4; tick(); clrLines = 4'h0;
    tick(); check8("level_irq2_low", {7'h0, irq2}, 8'h00);
    expectReg("level_pending", 1, 8'h00);

    // Masking of source 7
    wr(0, 8'h00); wr(2, 8'h80);
    src = 8'h80; tick(); src = 8'h00;
    repeat (3) tick();
    expectReg("mask_pending", 1, 8'h80);
    expectReg("mask_active", 4, 8'h00);
    check8("mask_irq3", {7'h0, irq3}, 8'h00);
    wr(0, 8'h80);
    tick(); check8("mask_irq3_en", {7'h0, irq3}, 8'h01);
    wr(1, 8'h80); tick();

    // Collisions: edge set vs ack, then W1C plus ack
    wr(0, 8'h40); wr(2, 8'hC0); wr(3, 8'h40);
    src = 8'h40; tick(); src = 8'h00; tick();
    clrLines = 4'h8; tick(); clrLines = 4'h0;
    expectReg("coll_set_wins", 1, 8'h40);
    wr(0, 8'h80); wr(3, 8'h80);
    expectReg("coll_both_pending", 1, 8'hC0);
    addr = BASE + 16'd1; wdata = 8'h40; we = 1'b1; clrLines = 4'h8;
    tick(); we = 1'b0; clrLines = 4'h0;
    expectReg("coll_both_cleared", 1, 8'h00);
    check8("coll_irq3_low", {7'h0, irq3}, 8'h00);

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) src = 8'($urandom);
      addr     = ($urandom_range(0, 7) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 7));
      wdata    = 8'($urandom);
      we       = ($urandom_range(0, 3) == 0);
      re       = ($urandom_range(0, 1) == 0);
      clrLines = 4'($urandom) & 4'($urandom);
      tick();
    end
    we = 1'b0; re = 1'b0; clrLines = 4'h0; reset = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
